tc_sched: RTL and testbench
===========================

// Module: tc_sched
// PURPOSE
// Host-side sequencer for the tc_ctrl tensor-core controller. On start it reads A rows and
// B columns (K-packed DW_MUL lanes) from a 1-cycle-latency operand memory and streams them
// into tc_ctrl with the in_state/in_type protocol. It then collects the M*N results as an
// indexed stream and reports done, or err on timeout.
// PARAMETERS
// M 16 / K 16 / N 16 : matrix dims, same values as the tc_ctrl instance
// DW_MUL 8 : operand lane width; DW_ADD 32 : result width
// AW 8 : operand memory address width (>= clog2(B_BASE+N))
// B_BASE 16 : memory address of B column 0 (A row i at address i)
// TIMEOUT 1024 : max RUN cycles without a result beat before err
// PORTS
// clk           in  1            clock, rising edge
// reset         in  1            async, active-low reset
// start         in  1            pulse; begins a job when idle
// abort         in  1            sync abort; returns to IDLE
// busy          out 1            high from accept of start until done/err/abort
// done          out 1            1-cycle pulse when all M*N results delivered
// err           out 1            1-cycle pulse on timeout
// mem_rd_en     out 1            operand read strobe
// mem_rd_addr   out AW           operand read address
// mem_rd_data   in  DW_MUL*K     read data, valid exactly 1 cycle after mem_rd_en
// tc_enable     out 1            tc_ctrl enable
// tc_in_i       out DW_MUL*K     = mem_rd_data (combinational passthrough)
// tc_in_type    out 1            0 = A row, 1 = B column
// tc_in_state   out 1            1-cycle frame marker (open load / commit)
// tc_out_i      in  DW_ADD       tc_ctrl result
// tc_out_state  in  2            2'b01 = result beat valid; other codes ignored
// res_valid     out 1            result beat
// res_data      out DW_ADD       registered tc_out_i
// res_idx       out clog2(M*N)   row-major result index, 0..M*N-1
// BEHAVIOUR
// - Reset (async, reset=0): state IDLE; all outputs 0; counters 0.
// - FSM: IDLE -> OPEN -> LOAD_A -> LOAD_B -> COMMIT -> RUN -> IDLE.
// - IDLE: start=1 -> OPEN. start is ignored in every other state.
// - OPEN, 1 cycle: tc_enable=1, tc_in_state=1; issue read of addr 0.
// - LOAD_A, M cycles, beat k: tc_in_type=0, tc_in_i = row k. Each beat prefetches the next
//   address: row k+1, or B_BASE on k=M-1.
// - LOAD_B, N cycles, beat k: tc_in_type=1. Prefetch B_BASE+k+1; no read on k=N-1.
// - mem_rd_en is high exactly M+N cycles per job; no gaps, no stall support.
// - COMMIT, 1 cycle: tc_in_state=1, tc_in_type holds 1, no read.
// - tc_enable stays 1 from OPEN through the end of RUN.
// - RUN: each tc_out_state==2'b01 gives res_valid=1 on the next cycle, with
//   res_data=tc_out_i and res_idx=count; count then increments.
// - Beat M*N-1 asserts done together with its res_valid. Next state IDLE, busy=0,
//   tc_enable=0. tc_out_state beats outside RUN are dropped.
// - Timeout: idle counter clears on every RUN beat. On reaching TIMEOUT: err pulse, -> IDLE.
// - abort, any state: -> IDLE next cycle; tc_enable, tc_in_state and mem_rd_en drop to 0.
//   No done/err pulse. If abort and a result beat coincide, abort wins and the beat is dropped.
// - An abort or reset mid-job leaves tc_ctrl partially loaded. The next job's OPEN marker
//   restarts tc_ctrl's load.
// - Widths: res_idx wraps never (job ends at M*N-1). The timeout counter is
//   clog2(TIMEOUT+1) bits and saturates.
// TESTING
// 1 reset=0 mid-LOAD_A -> all outputs 0 in the same cycle. reset=1 then start -> clean job.
// 2 start, M=K=N=16, memory A[i]=i, B=B_BASE+j ->
//   - tc_in_state=1 at cycles 1 and 34
//   - tc_in_type flips at cycle 18
//   - mem_rd_addr sequence 0..15, 16..31
// 3 Full job against tc_ctrl -> 256 res_valid with res_idx 0..255, row-major, matching the
//   golden S file. done is coincident with idx 255.
// 4 start pulsed during RUN -> ignored; busy stays 1; exactly one done.
// 5 tc_out_state held 00 in RUN -> err pulse after exactly 1024 cycles; busy=0; no done.
// 6 abort in LOAD_B beat 5 -> next cycle IDLE; mem_rd_en=0; no done/err. A new start then
//   completes correctly.

Source files
------------

// File: rtl/tc_sched_if.sv
// Host/operand/tc_ctrl link bundle for tc_sched.
//   master : the scheduler (drives busy/done/err, memory reads, tc_ctrl load, result stream)
//   slave  : the environment (host control, operand memory, tc_ctrl result side)
// Signals:
//   start, abort            host control in
//   busy, done, err         host status out
//   mem_rd_en/addr/data     1-cycle-latency operand memory read port
//   tc_enable, tc_in,
//   tc_in_type, tc_in_state operand load stream into tc_ctrl
//   tc_out, tc_out_state    result beats from tc_ctrl (2'b01 = valid)
//   res_valid/data/idx      indexed, registered result stream
interface tc_sched_if #(
  parameter int unsigned M      = 16,
  parameter int unsigned K      = 16,
  parameter int unsigned N      = 16,
  parameter int unsigned DW_MUL = 8,
  parameter int unsigned DW_ADD = 32,
  parameter int unsigned AW     = 8
);
  localparam int unsigned IdxW = $clog2(M * N);

  logic                    start;
  logic                    abort;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic                    mem_rd_en;
  logic [AW-1:0]           mem_rd_addr;
  logic [DW_MUL*K-1:0]     mem_rd_data;
  logic                    tc_enable;
  logic [DW_MUL*K-1:0]     tc_in;
  logic                    tc_in_type;
  logic                    tc_in_state;
  logic [DW_ADD-1:0]       tc_out;
  logic [1:0]              tc_out_state;
  logic                    res_valid;
  logic [DW_ADD-1:0]       res_data;
  logic [IdxW-1:0]         res_idx;

  modport master (
    input  start, abort, mem_rd_data, tc_out, tc_out_state,
    output busy, done, err, mem_rd_en, mem_rd_addr, tc_enable, tc_in, tc_in_type,
           tc_in_state, res_valid, res_data, res_idx
  );

  modport slave (
    output start, abort, mem_rd_data, tc_out, tc_out_state,
    input  busy, done, err, mem_rd_en, mem_rd_addr, tc_enable, tc_in, tc_in_type,
           tc_in_state, res_valid, res_data, res_idx
  );
endinterface

// File: rtl/tc_sched.sv
// Host-side sequencer for tc_ctrl. On start it opens a load frame, streams M A-rows then
// N B-columns from a 1-cycle-latency operand memory into tc_ctrl, commits the frame, then
// collects M*N result beats as a row-major indexed stream. Ends with a done pulse, an err
// pulse on result timeout, or silently on abort.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     tc_sched_if master modport (host control/status, memory, tc_ctrl, results)
module tc_sched #(
  parameter int unsigned M       = 16,
  parameter int unsigned K       = 16,
  parameter int unsigned N       = 16,
  parameter int unsigned DW_MUL  = 8,
  parameter int unsigned DW_ADD  = 32,
  parameter int unsigned AW      = 8,
  parameter int unsigned B_BASE  = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  tc_sched_if.master bus
);
  localparam int unsigned IdxW  = $clog2(M * N);
  localparam int unsigned ToW   = $clog2(TIMEOUT + 1);
  localparam int unsigned MaxMN = (M > N) ? M : N;
  localparam int unsigned BeatW = $clog2(MaxMN) + 1;

  typedef enum logic [2:0] {StIdle, StOpen, StLoadA, StLoadB, StCommit, StRun} state_e;

  state_e              state_q;
  logic [BeatW-1:0]    beat_q;
  logic [IdxW-1:0]     idx_q;
  logic [ToW-1:0]      to_q;
  logic                busy_q, done_q, err_q;
  logic                rd_en_q;
  logic [AW-1:0]       rd_addr_q;
  logic                en_q, in_type_q, in_state_q;
  logic                res_valid_q;
  logic [DW_ADD-1:0]   res_data_q;
  logic [IdxW-1:0]     res_idx_q;
  logic [DW_MUL*K-1:0] operand;

  // Operand lanes go straight from memory to tc_ctrl; the read issued last cycle
  // lines up with the current load beat.
  assign operand         = bus.mem_rd_data;
  assign bus.tc_in       = operand;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.tc_enable   = en_q;
  assign bus.tc_in_type  = in_type_q;
  assign bus.tc_in_state = in_state_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_idx     = res_idx_q;

  // All outputs are registered: each branch sets the values seen during the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      idx_q       <= '0;
      to_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      en_q        <= 1'b0;
      in_type_q   <= 1'b0;
      in_state_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
    end else begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      in_state_q  <= 1'b0;
      res_valid_q <= 1'b0;
      if (bus.abort) begin
        // Abort beats everything, including a coincident result beat.
        state_q   <= StIdle;
        busy_q    <= 1'b0;
        en_q      <= 1'b0;
        in_type_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              state_q    <= StOpen;
              busy_q     <= 1'b1;
              en_q       <= 1'b1;
              in_state_q <= 1'b1;
              in_type_q  <= 1'b0;
              rd_en_q    <= 1'b1;
              rd_addr_q  <= '0;
              beat_q     <= '0;
              idx_q      <= '0;
              to_q       <= '0;
            end
          end
          StOpen: begin
            state_q   <= StLoadA;
            beat_q    <= '0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= (M == 1) ? AW'(B_BASE) : AW'(1);
          end
          StLoadA: begin
            if (beat_q == BeatW'(M - 1)) begin
              state_q   <= StLoadB;
              beat_q    <= '0;
              in_type_q <= 1'b1;
              rd_en_q   <= (N > 1);
              rd_addr_q <= AW'(B_BASE + 1);
            end else begin
              beat_q    <= beat_q + 1'b1;
              rd_en_q   <= 1'b1;
              // Last A beat prefetches B column 0.
              rd_addr_q <= (beat_q == BeatW'(M - 2)) ? AW'(B_BASE) : AW'(32'(beat_q) + 2);
            end
          end
          StLoadB: begin
            if (beat_q == BeatW'(N - 1)) begin
              state_q    <= StCommit;
              in_state_q <= 1'b1;
            end else begin
              beat_q    <= beat_q + 1'b1;
              rd_en_q   <= (beat_q != BeatW'(N - 2));
              rd_addr_q <= AW'(B_BASE + 32'(beat_q) + 2);
            end
          end
          StCommit: begin
            state_q <= StRun;
            to_q    <= '0;
          end
          StRun: begin
            if (bus.tc_out_state == 2'b01) begin
              res_valid_q <= 1'b1;
              res_data_q  <= bus.tc_out;
              res_idx_q   <= idx_q;
              to_q        <= '0;
              if (idx_q == IdxW'(M * N - 1)) begin
                done_q    <= 1'b1;
                state_q   <= StIdle;
                busy_q    <= 1'b0;
                en_q      <= 1'b0;
                in_type_q <= 1'b0;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end else if (to_q == ToW'(TIMEOUT - 1)) begin
              err_q     <= 1'b1;
              state_q   <= StIdle;
              busy_q    <= 1'b0;
              en_q      <= 1'b0;
              in_type_q <= 1'b0;
            end else if (to_q != ToW'(TIMEOUT)) begin
              to_q <= to_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tc_sched.sv
// Directed bench for tc_sched: reset, load sequencing, full result stream, start during
// RUN, timeout, abort during load and abort against a result beat.
module tb_tc_sched;
  localparam int unsigned M = 16, K = 16, N = 16, DW_MUL = 8, DW_ADD = 32, AW = 8;
  localparam int unsigned B_BASE = 16, TIMEOUT = 1024;
  localparam int NR = M * N;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;

  logic [DW_MUL*K-1:0] mem [256];
  logic [DW_MUL*K-1:0] mem_q;

  tc_sched_if #(.M(M), .K(K), .N(N), .DW_MUL(DW_MUL), .DW_ADD(DW_ADD), .AW(AW)) bus ();

  tc_sched #(
    .M(M), .K(K), .N(N), .DW_MUL(DW_MUL), .DW_ADD(DW_ADD), .AW(AW),
    .B_BASE(B_BASE), .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand memory, 1-cycle read latency.
  always @(posedge clk) if (bus.mem_rd_en) mem_q <= mem[bus.mem_rd_addr];
  assign bus.mem_rd_data = mem_q;

  always @(posedge clk) begin
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.err)  err_cnt  <= err_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gold(input int b);
    return 32'(b) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  function automatic logic [DW_MUL*K-1:0] lanes(input int v);
    logic [7:0] b8;
    b8 = 8'(v);
    return {K{b8}};
  endfunction

  // Pulse start and walk the job to cycle `last` (cycle 1 = OPEN), checking each cycle.
  task automatic load_job(input int last);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) tick();
      check_eq("busy", bus.busy, 1'b1);
      check_eq("tc_enable", bus.tc_enable, 1'b1);
      check_eq("in_state", bus.tc_in_state, (c == 1 || c == 34));
      check_eq("rd_en", bus.mem_rd_en, (c <= 32));
      if (c <= 34) check_eq("in_type", bus.tc_in_type, (c >= 18));
      if (c <= 32) check_eq("rd_addr", bus.mem_rd_addr, 64'(c - 1));
      if (c >= 2 && c <= 33) check_eq("tc_in", bus.tc_in, lanes(c - 2));
    end
  endtask

  // Feed M*N result beats from RUN; optional ignored-code gaps, stray start, abort.
  task automatic run_results(input int gap_every, input int start_at, input int abort_at);
    for (int b = 0; b < NR; b++) begin
      if (gap_every > 0 && (b % gap_every) == gap_every - 1) begin
        bus.tc_out_state = 2'b10;
        bus.tc_out       = 32'hDEAD_BEEF;
        tick();
        check_eq("gap_valid", bus.res_valid, 1'b0);
      end
      bus.tc_out_state = 2'b01;
      bus.tc_out       = gold(b);
      bus.start        = (b == start_at);
      bus.abort        = (b == abort_at);
      tick();
      bus.start        = 1'b0;
      bus.abort        = 1'b0;
      bus.tc_out_state = 2'b00;
      if (b == abort_at) begin
        check_eq("abort_beat_valid", bus.res_valid, 1'b0);
        check_eq("abort_beat_busy", bus.busy, 1'b0);
        check_eq("abort_beat_done", bus.done, 1'b0);
        return;
      end
      check_eq("res_valid", bus.res_valid, 1'b1);
      check_eq("res_idx", bus.res_idx, 64'(b));
      check_eq("res_data", bus.res_data, gold(b));
      check_eq("done", bus.done, (b == NR - 1));
      check_eq("run_busy", bus.busy, (b != NR - 1));
    end
    check_eq("end_enable", bus.tc_enable, 1'b0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq(tag, {bus.busy, bus.done, bus.err, bus.mem_rd_en, bus.tc_enable,
                   bus.tc_in_type, bus.tc_in_state, bus.res_valid}, 8'h00);
  endtask

  initial begin
    int d0, e0, lat;
    bit got;
    for (int a = 0; a < 256; a++) mem[a] = lanes(a);
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.tc_out       = '0;
    bus.tc_out_state = 2'b00;
    tick();
    tick();
    check_quiet("reset_outputs");
    check_eq("reset_addr", bus.mem_rd_addr, 0);
    check_eq("reset_idx", bus.res_idx, 0);
    rst_n = 1'b1;
    tick();

    // Async reset mid-LOAD_A.
    load_job(5);
    #2 rst_n = 1'b0;
    #1;
    check_quiet("async_reset_outputs");
    check_eq("async_reset_addr", bus.mem_rd_addr, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Clean full job with ignored-code gaps, then a stray beat in IDLE.
    d0 = done_cnt;
    load_job(35);
    run_results(7, -1, -1);
    bus.tc_out_state = 2'b01;
    tick();
    bus.tc_out_state = 2'b00;
    check_eq("idle_beat_dropped", bus.res_valid, 1'b0);
    tick();
    check_eq("one_done_job1", done_cnt, d0 + 1);

    // start pulsed during RUN is ignored.
    d0 = done_cnt;
    load_job(35);
    run_results(0, 100, -1);
    tick();
    tick();
    check_eq("no_restart_busy", bus.busy, 1'b0);
    check_eq("one_done_job2", done_cnt, d0 + 1);

    // Timeout with tc_out_state held at 00.
    d0 = done_cnt;
    e0 = err_cnt;
    load_job(35);
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= TIMEOUT + 100 && !got; i++) begin
      tick();
      if (bus.err) begin
        got = 1'b1;
        lat = i;
      end
    end
    check_eq("timeout_seen", got, 1'b1);
    check_eq("timeout_latency", lat, TIMEOUT);
    check_eq("timeout_busy", bus.busy, 1'b0);
    check_eq("timeout_enable", bus.tc_enable, 1'b0);
    tick();
    check_eq("err_pulse", bus.err, 1'b0);
    check_eq("timeout_no_done", done_cnt, d0);
    check_eq("one_err", err_cnt, e0 + 1);

    // Abort in LOAD_B beat 5.
    d0 = done_cnt;
    e0 = err_cnt;
    load_job(23);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_quiet("abort_load_quiet");
    tick();
    tick();
    check_quiet("abort_stays_idle");

    // Abort coinciding with a result beat, then a clean job.
    load_job(35);
    run_results(0, -1, 10);
    tick();
    check_eq("abort_no_done", done_cnt, d0);
    check_eq("abort_no_err", err_cnt, e0);
    load_job(35);
    run_results(5, -1, -1);
    tick();
    tick();
    check_eq("after_abort_done", done_cnt, d0 + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
